// File: rtl/fetch_if_id_stage_pkg.sv
// Shared ISA constants, fetch FSM states and the IF/ID register layout
// used by fetch, decode and the hazard detector.
package fetch_if_id_stage_pkg;

   localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
   localparam logic [15:0] NOP_INSTR_DEF   = 16'h0800;
   localparam logic [4:0]  HALT_OPCODE_DEF = 5'b00000;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HALT  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [15:0] pc_inc;
      logic [15:0] instr;
   } if_id_t;

   function automatic logic [4:0] op_code(input logic [15:0] instr);
      return instr[15:11];
   endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: {valid, pc_inc, instr}, flush beats hold beats load.
// Latency: one cycle from d to q.
// Backpressure: hold freezes contents; flush inserts a NOP bubble.
module if_id_latch
   import fetch_if_id_stage_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        flush,
   input  logic [15:0] instr_d,
   input  logic [15:0] pc_inc_d,
   output logic [15:0] instr_q,
   output logic [15:0] pc_inc_q,
   output logic        valid_q
);

   if_id_t r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '{valid: 1'b0, pc_inc: 16'h0000, instr: NOP_INSTR};
      end else if (flush) begin
         r <= '{valid: 1'b0, pc_inc: 16'h0000, instr: NOP_INSTR};
      end else if (!hold) begin
         r <= '{valid: 1'b1, pc_inc: pc_inc_d, instr: instr_d};
      end
   end

   assign instr_q  = r.instr;
   assign pc_inc_q = r.pc_inc;
   assign valid_q  = r.valid;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Fetch stage: owns the PC, requests instructions and fills IF/ID.
// Latency: one cycle imem_ready -> ID_instr; a redirect costs at least one bubble.
// Backpressure: stall holds PC and IF/ID; a busy memory inserts bubbles.
module fetch_if_id_stage
   import fetch_if_id_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
   parameter logic [15:0] NOP_INSTR   = NOP_INSTR_DEF,
   parameter logic [4:0]  HALT_OPCODE = HALT_OPCODE_DEF,
   parameter int          PERF_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect_en,
   input  logic [15:0]       redirect_pc,
   output logic [15:0]       imem_addr,
   output logic              imem_rd_en,
   input  logic [15:0]       imem_instr,
   input  logic              imem_ready,
   output logic [15:0]       ID_instr,
   output logic [15:0]       ID_pc_inc,
   output logic              ID_valid,
   output logic              halted,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [PERF_W-1:0] SC_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

   fetch_state_e state, state_nxt;
   logic [15:0]  pc, pc_nxt, pc_plus2;
   logic         latch_hold, latch_flush, count_stall;

   assign pc_plus2 = pc + 16'd2;

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      latch_hold  = 1'b0;
      latch_flush = 1'b0;
      count_stall = 1'b0;
      case (state)
         S_FETCH: begin
            if (redirect_en) begin
               pc_nxt      = redirect_pc & 16'hFFFE;
               latch_flush = 1'b1;
            end else if (stall) begin
               latch_hold  = 1'b1;
               count_stall = 1'b1;
            end else if (imem_ready) begin
               pc_nxt = pc_plus2;
               if (op_code(imem_instr) == HALT_OPCODE) begin
                  state_nxt = S_HALT;
               end
            end else begin
               latch_flush = 1'b1;
               count_stall = 1'b1;
            end
         end
         S_HALT: begin
            // Only a redirect (HALT fetched down a wrong path) resumes fetch.
            if (redirect_en) begin
               pc_nxt      = redirect_pc & 16'hFFFE;
               latch_flush = 1'b1;
               state_nxt   = S_FETCH;
            end else begin
               latch_hold = 1'b1;
            end
         end
         default: begin
            state_nxt   = S_FETCH;
            latch_flush = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_FETCH;
         pc           <= RESET_PC;
         stall_cycles <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (count_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + SC_ONE;
         end
      end
   end

   if_id_latch #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id_latch (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (latch_hold),
      .flush   (latch_flush),
      .instr_d (imem_instr),
      .pc_inc_d(pc_plus2),
      .instr_q (ID_instr),
      .pc_inc_q(ID_pc_inc),
      .valid_q (ID_valid)
   );

   assign imem_addr  = pc;
   assign imem_rd_en = (state == S_FETCH);
   assign halted     = (state == S_HALT);

endmodule
